// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive packet controller: FSM encodings,
// PID codes, and the PID nibble-complement helper.
package usb_rx_pkg;

   localparam logic [7:0] SYNC_DEFAULT = 8'h80;

   typedef logic [3:0] state_t;

   localparam state_t S_IDLE       = 4'd0;
   localparam state_t S_RCV_SYNC   = 4'd1;
   localparam state_t S_CMP_SYNC   = 4'd2;
   localparam state_t S_RCV_PID    = 4'd3;
   localparam state_t S_CMP_PID    = 4'd4;
   localparam state_t S_RCV_BYTE   = 4'd5;
   localparam state_t S_STORE      = 4'd6;
   localparam state_t S_EOP_WAIT   = 4'd7;
   localparam state_t S_EIDLE_WAIT = 4'd8;
   localparam state_t S_EIDLE      = 4'd9;

   typedef enum logic [3:0] {
      PID_OUT   = 4'h1,
      PID_IN    = 4'h9,
      PID_SOF   = 4'h5,
      PID_SETUP = 4'hD,
      PID_DATA0 = 4'h3,
      PID_DATA1 = 4'hB,
      PID_ACK   = 4'h2,
      PID_NAK   = 4'hA,
      PID_STALL = 4'hE
   } pid_e;

   // A PID byte carries its 4-bit code in the low nibble and the complement above it.
   function automatic logic pid_ok(input logic [7:0] b);
      return b[7:4] == ~b[3:0];
   endfunction

endpackage

// File: rtl/usb_rx_len_cnt.sv
// Bit counter within the current byte and saturating payload byte counter.
// overflow flags that one more byte would exceed MAX_BYTES.
module usb_rx_len_cnt #(
   parameter int MAX_BYTES = 64,
   parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             bit_clear,
   input  logic             bit_inc,
   input  logic             byte_inc,
   output logic             bit_zero,
   output logic             overflow,
   output logic [CNT_W-1:0] byte_cnt
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

   logic [2:0] bit_cnt;

   // A completed byte restarts the bit count even if a strobe lands the same cycle.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                  bit_cnt <= '0;
      else if (clear || bit_clear) bit_cnt <= '0;
      else if (bit_inc)            bit_cnt <= bit_cnt + 3'd1;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                     byte_cnt <= '0;
      else if (clear)                 byte_cnt <= '0;
      else if (byte_inc && !overflow) byte_cnt <= byte_cnt + 1'b1;
   end

   assign bit_zero = (bit_cnt == 3'd0);
   assign overflow = (byte_cnt == MAX_CNT);

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// USB receive packet control: SYNC/PID validation, payload gating to the RX FIFO,
// length limit and end-of-packet classification. Define USB_RX_PID_CHECK_EN to reject bad PIDs.
module usb_rx_pkt_ctrl
   import usb_rx_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
   parameter int         MAX_BYTES = 64,
   parameter int         CNT_W     = $clog2(MAX_BYTES + 1)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             d_edge,
   input  logic             eop,
   input  logic             shift_enable,
   input  logic [7:0]       rcv_data,
   input  logic             byte_received,
   output logic             rcving,
   output logic             w_enable,
   output logic             r_error,
   output logic [3:0]       pid,
   output logic             pid_valid,
   output logic [CNT_W-1:0] byte_cnt,
   output logic             pkt_done
);

   state_t state, nxt;
   logic   eop_se;
   logic   start;
   logic   pid_accept;
   logic   bit_zero;
   logic   overflow;

   assign eop_se = eop && shift_enable;
   assign start  = (nxt == S_RCV_SYNC) && (state != S_RCV_SYNC);

`ifdef USB_RX_PID_CHECK_EN
   assign pid_accept = pid_ok(rcv_data);
`else
   assign pid_accept = 1'b1;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= S_IDLE;
      else        state <= nxt;
   end

   // byte_received is tested before eop&se so an in-flight byte is never lost.
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:       if (d_edge) nxt = S_RCV_SYNC;
         S_RCV_SYNC: begin
            if (byte_received) nxt = S_CMP_SYNC;
            else if (eop_se)   nxt = S_EIDLE;
         end
         S_CMP_SYNC:   nxt = (rcv_data == SYNC_BYTE) ? S_RCV_PID : S_EIDLE_WAIT;
         S_RCV_PID: begin
            if (byte_received) nxt = S_CMP_PID;
            else if (eop_se)   nxt = S_EIDLE;
         end
         S_CMP_PID:    nxt = pid_valid ? S_RCV_BYTE : S_EIDLE_WAIT;
         S_RCV_BYTE: begin
            if (byte_received) nxt = S_STORE;
            else if (eop_se)   nxt = bit_zero ? S_EOP_WAIT : S_EIDLE;
         end
         S_STORE:      nxt = overflow ? S_EIDLE_WAIT : S_RCV_BYTE;
         S_EOP_WAIT:   if (d_edge) nxt = S_IDLE;
         S_EIDLE_WAIT: if (eop_se) nxt = S_EIDLE;
         S_EIDLE:      if (d_edge) nxt = S_RCV_SYNC;
         default:      nxt = S_IDLE;
      endcase
   end

   // PID is captured on its byte_received so pid_valid is visible during CMP_PID.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pid       <= 4'h0;
         pid_valid <= 1'b0;
      end else if (start) begin
         pid       <= 4'h0;
         pid_valid <= 1'b0;
      end else if ((state == S_RCV_PID) && byte_received && pid_accept) begin
         pid       <= rcv_data[3:0];
         pid_valid <= 1'b1;
      end
   end

   usb_rx_len_cnt #(
      .MAX_BYTES (MAX_BYTES),
      .CNT_W     (CNT_W)
   ) u_len_cnt (
      .clk       (clk),
      .n_rst     (n_rst),
      .clear     (start),
      .bit_clear (byte_received),
      .bit_inc   (shift_enable && ((state == S_RCV_PID) || (state == S_RCV_BYTE))),
      .byte_inc  (state == S_STORE),
      .bit_zero  (bit_zero),
      .overflow  (overflow),
      .byte_cnt  (byte_cnt)
   );

   assign w_enable = (state == S_STORE) && !overflow;
   assign r_error  = (state == S_EIDLE_WAIT) || (state == S_EIDLE);
   assign rcving   = !((state == S_IDLE) || (state == S_EOP_WAIT) || (state == S_EIDLE));
   assign pkt_done = (state == S_EOP_WAIT) && d_edge;

endmodule

// File: doc/usb_rx_pkt_ctrl.md
Name: usb_rx_pkt_ctrl

Overview:
Parametrised USB receiver packet control unit that sits between the bit-level receive datapath (edge detector, shift register, timer) and the RX FIFO.
- Validates SYNC, then decodes and checks the PID, then gates payload bytes into the FIFO.
- Counts payload length and enforces a maximum packet size.
- Classifies every packet end as clean or error; r_error is sticky until the next packet starts.

Parameters:
SYNC_BYTE, 8'h80, expected SYNC value as presented on rcv_data.
MAX_BYTES, 64, maximum payload bytes after the PID (1..1023).
CNT_W, $clog2(MAX_BYTES+1), width of byte_cnt.

Ports:
clk  in  1  system clock
n_rst  in  1  reset; asynchronous, active-low
d_edge  in  1  single-cycle pulse on a D+/D- transition
eop  in  1  EOP level currently detected on the bus
shift_enable  in  1  single-cycle bit-sample strobe
rcv_data  in  8  last complete byte from the shift register
byte_received  in  1  single-cycle pulse; rcv_data is valid this cycle
rcving  out  1  high from the first SYNC edge until packet end
w_enable  out  1  single-cycle FIFO write strobe per payload byte
r_error  out  1  sticky receive error
pid  out  4  latched PID (rcv_data[3:0] of the PID byte)
pid_valid  out  1  high while pid holds the current packet's checked PID
byte_cnt  out  CNT_W  payload bytes written for the current packet
pkt_done  out  1  single-cycle pulse when a packet ends cleanly

Behaviour:
- Moore FSM. States: IDLE, RCV_SYNC, CMP_SYNC, RCV_PID, CMP_PID, RCV_BYTE, STORE, EOP_WAIT, EIDLE_WAIT, EIDLE.
- Reset values: state IDLE; all outputs 0; pid 0; byte_cnt 0; bit_cnt 0.
- EOP test, written "eop&se" below: eop && shift_enable.
- Bit counter: bit_cnt (3 bits) increments on shift_enable in RCV_PID and RCV_BYTE; cleared on byte_received and on entry to RCV_SYNC.
- IDLE: d_edge -> RCV_SYNC.
- RCV_SYNC: byte_received -> CMP_SYNC; eop&se -> EIDLE.
- CMP_SYNC: takes 1 cycle. rcv_data==SYNC_BYTE -> RCV_PID, else -> EIDLE_WAIT.
- RCV_PID: byte_received -> CMP_PID; eop&se -> EIDLE.
- CMP_PID: takes 1 cycle.
  - rcv_data[7:4]==~rcv_data[3:0]: latch pid, set pid_valid -> RCV_BYTE.
  - otherwise -> EIDLE_WAIT.
- RCV_BYTE: byte_received -> STORE.
  - eop&se with bit_cnt==0 -> EOP_WAIT (clean end).
  - eop&se with bit_cnt!=0 -> EIDLE (partial byte).
- STORE: w_enable=1 for exactly 1 cycle; byte_cnt += 1.
  - New count > MAX_BYTES: do not assert w_enable; -> EIDLE_WAIT (overflow).
  - Otherwise -> RCV_BYTE.
- EOP_WAIT: d_edge (bus returns to idle) -> IDLE, with pkt_done pulsed in that transition cycle. A zero-byte payload is legal.
- EIDLE_WAIT: r_error=1, rcving=1; eop&se -> EIDLE.
- EIDLE: r_error=1, rcving=0; d_edge -> RCV_SYNC. r_error clears on that transition, and pid_valid and byte_cnt clear as well.
- rcving=1 in every state except IDLE, EOP_WAIT and EIDLE.
- byte_cnt and pid are held after packet end and cleared on entry to RCV_SYNC.
- Priority: byte_received beats eop&se in the same cycle; the byte is processed and the EOP is re-sampled on the next strobe.
- n_rst asserted mid-packet returns all state and outputs to reset values immediately; no w_enable is issued.
- Latency: w_enable fires 1 cycle after byte_received. pid_valid rises 1 cycle after the PID byte_received.

Optional Feature:
USB_RX_PID_CHECK_EN
- Defined: CMP_PID performs the nibble-complement check as above.
- Undefined: any PID byte is accepted and latched. CMP_PID always -> RCV_BYTE. PID errors are never flagged.

Decomposition:
- Package usb_rx_pkg: state enum (logic [3:0]), PID constants (OUT, IN, SOF, SETUP, DATA0, DATA1, ACK, NAK, STALL), default SYNC constant.
- One sub-module, usb_rx_len_cnt: holds the bit counter and the saturating byte counter. It has clear and increment inputs, and outputs bit_zero and overflow.

Test Plan:
- SYNC 8'h80, PID 8'hC3 (DATA0), bytes 8'hA5, 8'h5A, clean EOP -> 2 w_enable pulses, pid=4'h3, byte_cnt=2, pkt_done=1, r_error=0.
- SYNC 8'h81 -> EIDLE_WAIT, r_error=1 and held through EOP; next d_edge clears r_error.
- PID 8'hC4 with USB_RX_PID_CHECK_EN defined -> r_error=1, no w_enable; with it undefined -> pid=4'h4, packet proceeds.
- MAX_BYTES=4, send 5 payload bytes -> exactly 4 w_enable pulses, r_error=1 after the 5th byte_received.
- EOP after 3 bits of a payload byte -> EIDLE, r_error=1, pkt_done=0.
- n_rst pulsed during RCV_BYTE -> all outputs 0 in the next cycle, state IDLE; a following packet is received normally.
